// File: rtl/aes_stream_frontend.sv
// Word-serial host front end for a 128-bit AES core: loads plaintext and key DW bits at a
// time, pulses the core start, captures the ciphertext and streams it back low word first.
module aes_stream_frontend #(
    parameter int DW       = 8,
    parameter bit KEEP_KEY = 1'b1
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic [1:0]    cmd,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    output logic          ready,
    output logic          ok,
    output logic          err,
    output logic [127:0]  key_o,
    output logic [127:0]  pt_o,
    output logic          core_start,
    input  logic          core_done,
    input  logic [127:0]  ct_i
);
    localparam int NW = 128 / DW;
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NW - 1);

    localparam logic [1:0] CMD_ID = 2'b00;
    localparam logic [1:0] CMD_ST = 2'b01;
    localparam logic [1:0] CMD_SK = 2'b10;
    localparam logic [1:0] CMD_SP = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_PT,
        S_LOAD_KEY,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic [1:0]    cmd_q_reg;
    logic          pt_vld_reg;
    logic          key_vld_reg;
    logic          last_reg;
    logic [127:0]  ct_reg;
    logic [DW-1:0] ct_words [NW];
    logic [6:0]    wr_base;
    logic          cmd_edge;

    // A command only fires on its first cycle, so a level held by the host acts once.
    assign cmd_edge = (cmd != CMD_ID) && (cmd_q_reg == CMD_ID);
    assign wr_base  = 7'(cnt_reg) * 7'(DW);

    for (genvar gi = 0; gi < NW; gi++) begin : g_ct_words
        assign ct_words[gi] = ct_reg[gi*DW +: DW];
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            cmd_q_reg   <= CMD_ID;
            pt_vld_reg  <= 1'b0;
            key_vld_reg <= 1'b0;
            last_reg    <= 1'b0;
            ct_reg      <= '0;
            key_o       <= '0;
            pt_o        <= '0;
            dout        <= '0;
            dout_vld    <= 1'b0;
            ready       <= 1'b1;
            ok          <= 1'b0;
            err         <= 1'b0;
            core_start  <= 1'b0;
        end else begin
            cmd_q_reg  <= cmd;
            err        <= 1'b0;
            core_start <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (cmd_edge) begin
                        case (cmd)
                            CMD_SP: begin
                                state_reg  <= S_LOAD_PT;
                                cnt_reg    <= '0;
                                pt_vld_reg <= 1'b0;
                                ok         <= 1'b0;
                                ready      <= 1'b0;
                            end
                            CMD_SK: begin
                                state_reg   <= S_LOAD_KEY;
                                cnt_reg     <= '0;
                                key_vld_reg <= 1'b0;
                                ok          <= 1'b0;
                                ready       <= 1'b0;
                            end
                            default: begin
                                if (pt_vld_reg && key_vld_reg) begin
                                    state_reg  <= S_RUN;
                                    core_start <= 1'b1;
                                    ok         <= 1'b0;
                                    ready      <= 1'b0;
                                end else begin
                                    err <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                S_LOAD_PT: begin
                    if (cmd == CMD_ID) begin
                        err       <= 1'b1;
                        state_reg <= S_IDLE;
                        ready     <= 1'b1;
                    end else begin
                        pt_o[wr_base +: DW] <= din;
                        if (cnt_reg == CNT_LAST) begin
                            pt_vld_reg <= 1'b1;
                            state_reg  <= S_IDLE;
                            ready      <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                S_LOAD_KEY: begin
                    if (cmd == CMD_ID) begin
                        err       <= 1'b1;
                        state_reg <= S_IDLE;
                        ready     <= 1'b1;
                    end else begin
                        key_o[wr_base +: DW] <= din;
                        if (cnt_reg == CNT_LAST) begin
                            key_vld_reg <= 1'b1;
                            state_reg   <= S_IDLE;
                            ready       <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    // A done seen while start is still high belongs to a previous run.
                    if (core_done && !core_start) begin
                        ct_reg    <= ct_i;
                        cnt_reg   <= '0;
                        last_reg  <= 1'b0;
                        state_reg <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (last_reg) begin
                        dout_vld    <= 1'b0;
                        ok          <= 1'b1;
                        pt_vld_reg  <= 1'b0;
                        key_vld_reg <= KEEP_KEY;
                        last_reg    <= 1'b0;
                        state_reg   <= S_IDLE;
                        ready       <= 1'b1;
                    end else begin
                        dout     <= ct_words[cnt_reg];
                        dout_vld <= 1'b1;
                        if (cnt_reg == CNT_LAST) begin
                            last_reg <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    ready     <= 1'b1;
                end
            endcase
        end
    end

endmodule
